// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - BCD time types, limits and digit helpers shared by the clock blocks
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t BCD_MAX_SEC = 8'h59;
  localparam bcd2_t BCD_MAX_MIN = 8'h59;
  localparam bcd2_t BCD_MAX_HR  = 8'h23;

  // With both nibbles already <= 9, a plain unsigned compare orders BCD values correctly.
  function automatic logic bcd2_valid(bcd2_t v, bcd2_t max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

  function automatic bcd2_t bcd2_inc(bcd2_t v);
    bcd2_t r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic bcd2_t bcd2_to_12h(bcd2_t hh);
    bcd2_t r;
    r = hh;
    case (hh)
      8'h00: r = 8'h12;
      8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19: r = hh - 8'h12;
      8'h20: r = 8'h08;
      8'h21: r = 8'h09;
      8'h22: r = 8'h10;
      8'h23: r = 8'h11;
      default: r = hh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping at MAX, with load and carry-out
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX       = BCD_MAX_SEC,
  parameter bcd2_t RESET_VAL = 8'h00
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  load,
  input  bcd2_t load_val,
  output bcd2_t value,
  output logic  carry
);

  assign carry = inc && (value == MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= carry ? 8'h00 : bcd2_inc(value);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - BCD HH:MM:SS time-of-day counter with validated set and 12-hour display
module time_keeper
  import clock_pkg::*;
#(
  parameter logic [7:0] RESET_HH = 8'h00,
  parameter logic [7:0] RESET_MM = 8'h00,
  parameter logic [7:0] RESET_SS = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [7:0] disp_hh_bcd,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       set_err
);

  logic tick_q;
  logic advance;
  logic set_valid;
  logic load;
  logic inc;
  logic ss_carry;
  logic mm_carry;
  logic hh_carry;

  assign advance   = tick_in && !tick_q;
  assign set_valid = bcd2_valid(set_hh, BCD_MAX_HR) &&
                     bcd2_valid(set_mm, BCD_MAX_MIN) &&
                     bcd2_valid(set_ss, BCD_MAX_SEC);
  assign load      = set_en && set_valid;
  // Any set request, accepted or rejected, swallows a coincident tick edge.
  assign inc       = advance && !set_en;

  bcd_mod_counter #(.MAX(BCD_MAX_SEC), .RESET_VAL(RESET_SS)) u_ss (
    .clk(clk), .rst(rst), .inc(inc), .load(load), .load_val(set_ss),
    .value(ss_bcd), .carry(ss_carry)
  );

  bcd_mod_counter #(.MAX(BCD_MAX_MIN), .RESET_VAL(RESET_MM)) u_mm (
    .clk(clk), .rst(rst), .inc(ss_carry), .load(load), .load_val(set_mm),
    .value(mm_bcd), .carry(mm_carry)
  );

  bcd_mod_counter #(.MAX(BCD_MAX_HR), .RESET_VAL(RESET_HH)) u_hh (
    .clk(clk), .rst(rst), .inc(mm_carry), .load(load), .load_val(set_hh),
    .value(hh_bcd), .carry(hh_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= 1'b1;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      tick_q    <= tick_in;
      sec_pulse <= inc;
      day_pulse <= hh_carry;
      set_err   <= set_en && !set_valid;
    end
  end

  assign disp_hh_bcd = bcd2_to_12h(hh_bcd);
  assign pm          = (hh_bcd >= 8'h12);

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed self-checking bench for time_keeper
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       set_en = 1'b0;
  logic [7:0] set_hh = 8'h00;
  logic [7:0] set_mm = 8'h00;
  logic [7:0] set_ss = 8'h00;

  logic [7:0] hh, mm, ss, disp;
  logic       pm, sec_p, day_p, set_err;
  logic [7:0] r_hh, r_mm, r_ss, r_disp;
  logic       r_pm, r_sec_p, r_day_p, r_set_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  time_keeper dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .set_en(set_en),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .hh_bcd(hh), .mm_bcd(mm), .ss_bcd(ss), .disp_hh_bcd(disp), .pm(pm),
    .sec_pulse(sec_p), .day_pulse(day_p), .set_err(set_err)
  );

  time_keeper #(.RESET_HH(8'h12), .RESET_MM(8'h00), .RESET_SS(8'h00)) dut_r (
    .clk(clk), .rst(rst), .tick_in(tick_in), .set_en(set_en),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .hh_bcd(r_hh), .mm_bcd(r_mm), .ss_bcd(r_ss), .disp_hh_bcd(r_disp), .pm(r_pm),
    .sec_pulse(r_sec_p), .day_pulse(r_day_p), .set_err(r_set_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_en = 1'b1; set_hh = h; set_mm = m; set_ss = s;
    step();
    set_en = 1'b0;
  endtask

  task automatic test_reset();
    tick_in = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({hh, mm, ss} !== 24'h000000) begin
      errors++; $display("FAIL reset_time got %h want 000000", {hh, mm, ss});
    end
    checks++;
    if ({sec_p, day_p, set_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {sec_p, day_p, set_err});
    end
    checks++;
    if ({disp, pm} !== {8'h12, 1'b0}) begin
      errors++; $display("FAIL reset_disp got %h/%b want 12/0", disp, pm);
    end
    checks++;
    if ({r_hh, r_mm, r_ss, r_disp, r_pm} !== {24'h120000, 8'h12, 1'b1}) begin
      errors++; $display("FAIL reset_param got %h %h/%b want 120000 12/1", {r_hh, r_mm, r_ss}, r_disp, r_pm);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (sec_p !== 1'b0 || {hh, mm, ss} !== 24'h000000) begin
        errors++; $display("FAIL held_tick cyc %0d got %h pulse %b want 000000 0", i, {hh, mm, ss}, sec_p);
      end
    end
    tick_in = 1'b0;
    step();
  endtask

  task automatic test_count60();
    int pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      tick_in = 1'b1;
      step();
      if (sec_p === 1'b1) pulses++;
      if (i == 59) begin
        checks++;
        if ({hh, mm, ss} !== 24'h000059) begin
          errors++; $display("FAIL count_59 got %h want 000059", {hh, mm, ss});
        end
      end
      tick_in = 1'b0;
      step();
      if (sec_p === 1'b1) pulses++;
    end
    checks++;
    if ({hh, mm, ss} !== 24'h000100) begin
      errors++; $display("FAIL count_60 got %h want 000100", {hh, mm, ss});
    end
    checks++;
    if (pulses !== 60) begin
      errors++; $display("FAIL sec_pulse_count got %0d want 60", pulses);
    end
  endtask

  task automatic test_day_wrap();
    int days = 0;
    do_set(8'h23, 8'h59, 8'h58);
    checks++;
    if ({hh, mm, ss, sec_p, day_p} !== {24'h235958, 2'b00}) begin
      errors++; $display("FAIL set_235958 got %h %b%b want 235958 00", {hh, mm, ss}, sec_p, day_p);
    end
    tick_in = 1'b1; step(); tick_in = 1'b0;
    if (day_p === 1'b1) days++;
    checks++;
    if ({hh, mm, ss, sec_p} !== {24'h235959, 1'b1}) begin
      errors++; $display("FAIL tick_235959 got %h %b want 235959 1", {hh, mm, ss}, sec_p);
    end
    step();
    if (day_p === 1'b1) days++;
    tick_in = 1'b1; step(); tick_in = 1'b0;
    checks++;
    if ({hh, mm, ss, sec_p, day_p} !== {24'h000000, 2'b11}) begin
      errors++; $display("FAIL day_wrap got %h %b%b want 000000 11", {hh, mm, ss}, sec_p, day_p);
    end
    if (day_p === 1'b1) days++;
    step();
    if (day_p === 1'b1) days++;
    checks++;
    if (days !== 1) begin
      errors++; $display("FAIL day_pulse_count got %0d want 1", days);
    end
  endtask

  task automatic test_set_validation();
    logic [7:0] bad_h [2] = '{8'h24, 8'h12};
    logic [7:0] bad_m [2] = '{8'h00, 8'h5A};
    logic [7:0] map_in  [6] = '{8'h00, 8'h09, 8'h11, 8'h12, 8'h20, 8'h23};
    logic [7:0] map_out [6] = '{8'h12, 8'h09, 8'h11, 8'h12, 8'h08, 8'h11};
    logic       map_pm  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 2; i++) begin
      do_set(bad_h[i], bad_m[i], 8'h00);
      checks++;
      if ({hh, mm, ss, set_err} !== {24'h000000, 1'b1}) begin
        errors++; $display("FAIL bad_set %0d got %h err %b want 000000 1", i, {hh, mm, ss}, set_err);
      end
      step();
      checks++;
      if (set_err !== 1'b0) begin
        errors++; $display("FAIL set_err_width %0d got %b want 0", i, set_err);
      end
    end
    do_set(8'h13, 8'h45, 8'h09);
    checks++;
    if ({hh, mm, ss, disp, pm, set_err} !== {24'h134509, 8'h01, 2'b10}) begin
      errors++; $display("FAIL set_134509 got %h %h/%b err %b want 134509 01/1 0", {hh, mm, ss}, disp, pm, set_err);
    end
    for (int i = 0; i < 6; i++) begin
      do_set(map_in[i], 8'h30, 8'h00);
      checks++;
      if ({disp, pm} !== {map_out[i], map_pm[i]}) begin
        errors++; $display("FAIL map12 hh %h got %h/%b want %h/%b", map_in[i], disp, pm, map_out[i], map_pm[i]);
      end
    end
  endtask

  task automatic test_set_tick_collision();
    tick_in = 1'b0; step();
    tick_in = 1'b1;
    do_set(8'h10, 8'h00, 8'h00);
    checks++;
    if ({hh, mm, ss, sec_p} !== {24'h100000, 1'b0}) begin
      errors++; $display("FAIL collide got %h %b want 100000 0", {hh, mm, ss}, sec_p);
    end
    step();
    checks++;
    if ({hh, mm, ss, sec_p} !== {24'h100000, 1'b0}) begin
      errors++; $display("FAIL collide_hold got %h %b want 100000 0", {hh, mm, ss}, sec_p);
    end
    tick_in = 1'b0; step();
    tick_in = 1'b1; step();
    checks++;
    if ({hh, mm, ss, sec_p} !== {24'h100001, 1'b1}) begin
      errors++; $display("FAIL after_collide got %h %b want 100001 1", {hh, mm, ss}, sec_p);
    end
    tick_in = 1'b0; step();
  endtask

  task automatic test_reset_mid();
    do_set(8'h05, 8'h06, 8'h07);
    checks++;
    if ({r_hh, r_mm, r_ss} !== 24'h050607) begin
      errors++; $display("FAIL preset_050607 got %h want 050607", {r_hh, r_mm, r_ss});
    end
    rst = 1'b1; tick_in = 1'b1;
    set_en = 1'b1; set_hh = 8'h01; set_mm = 8'h02; set_ss = 8'h03;
    step();
    rst = 1'b0; set_en = 1'b0;
    checks++;
    if ({r_hh, r_mm, r_ss, r_disp, r_pm} !== {24'h120000, 8'h12, 1'b1}) begin
      errors++; $display("FAIL mid_reset got %h %h/%b want 120000 12/1", {r_hh, r_mm, r_ss}, r_disp, r_pm);
    end
    checks++;
    if ({r_sec_p, r_day_p, r_set_err, sec_p, day_p, set_err} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_pulses got %b want 000000", {r_sec_p, r_day_p, r_set_err, sec_p, day_p, set_err});
    end
    checks++;
    if ({hh, mm, ss} !== 24'h000000) begin
      errors++; $display("FAIL mid_reset_default got %h want 000000", {hh, mm, ss});
    end
    step();
    checks++;
    if ({r_hh, r_mm, r_ss, r_sec_p} !== {24'h120000, 1'b0}) begin
      errors++; $display("FAIL post_reset_high got %h %b want 120000 0", {r_hh, r_mm, r_ss}, r_sec_p);
    end
    tick_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count60();
    test_day_wrap();
    test_set_validation();
    test_set_tick_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
